// File: rtl/adbg_biu_arb_if.sv
// Bundle of requester-side and BIU-side signals for the BIU arbiter.
// Latency: none (wires only).
// Backpressure: none here; biu_rdy and req_ack carry the flow control.
// Ports: master = the arbiter (drives req_ack/gnt/do/err and biu_*),
//        slave  = requesters plus BIU (drive req_* and biu_rdy/do/err).
interface adbg_biu_arb_if #(
    parameter int NREQ       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NREQ-1:0]            req_strb;
    logic [NREQ-1:0]            req_rw;
    logic [NREQ-1:0]            req_lock;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0] req_di;
    logic [NREQ*4-1:0]          req_word_size;
    logic [NREQ-1:0]            req_ack;
    logic [NREQ-1:0]            req_gnt;
    logic [DATA_WIDTH-1:0]      req_do;
    logic                       req_err;

    logic                       biu_strb;
    logic                       biu_rw;
    logic [ADDR_WIDTH-1:0]      biu_addr;
    logic [DATA_WIDTH-1:0]      biu_di;
    logic [3:0]                 biu_word_size;
    logic                       biu_rdy;
    logic [DATA_WIDTH-1:0]      biu_do;
    logic                       biu_err;

    modport master (
        input  req_strb, req_rw, req_lock, req_addr, req_di, req_word_size,
        output req_ack, req_gnt, req_do, req_err,
        output biu_strb, biu_rw, biu_addr, biu_di, biu_word_size,
        input  biu_rdy, biu_do, biu_err
    );

    modport slave (
        output req_strb, req_rw, req_lock, req_addr, req_di, req_word_size,
        input  req_ack, req_gnt, req_do, req_err,
        input  biu_strb, biu_rw, biu_addr, biu_di, biu_word_size,
        output biu_rdy, biu_do, biu_err
    );
endinterface

// File: rtl/adbg_biu_arb.sv
// Round-robin arbiter with lock, sharing one BIU among NREQ requesters.
// Latency: 1 cycle grant + 1 cycle strobe + BIU wait + 1 cycle ack.
// Backpressure: no grant while biu_rdy=0; access waits in WAIT for biu_rdy.
// Ports: biu_clk, biu_rst_n (async active-low), bus (adbg_biu_arb_if.master).
// Optional macro ADBG_BIU_ARB_TIMEOUT_EN: bounds WAIT to TIMEOUT_CYCLES, then
// acks with error and drains the late BIU response.
module adbg_biu_arb #(
    parameter int NREQ           = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            biu_clk,
    input  logic            biu_rst_n,
    adbg_biu_arb_if.master  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
        DRAIN,
`endif
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           last_q, last_d;      // current/last owner index
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic                    lock_q, lock_d;
    logic                    biu_rw_q, biu_rw_d;
    logic [ADDR_WIDTH-1:0]   biu_addr_q, biu_addr_d;
    logic [DATA_WIDTH-1:0]   biu_di_q, biu_di_d;
    logic [3:0]              biu_ws_q, biu_ws_d;
    logic [DATA_WIDTH-1:0]   req_do_q, req_do_d;
    logic                    req_err_q, req_err_d;
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    to_q, to_d;          // DONE was reached by timeout
`endif

    // Round-robin pick. While a lock is held only the owner is eligible;
    // gnt_q still holds the owner's one-hot in that case.
    logic                    lock_hold;
    logic [NREQ-1:0]         elig;
    logic [IW-1:0]           win;
    logic                    win_vld;
    int                      c;

    always_comb begin
        lock_hold = lock_q & bus.req_lock[last_q];
        elig      = lock_hold ? (bus.req_strb & gnt_q) : bus.req_strb;
        win       = '0;
        win_vld   = 1'b0;
        c         = 0;
        // Walk from farthest to nearest so the nearest eligible one after
        // last_q is written last and wins.
        for (int k = NREQ; k >= 1; k--) begin
            c = int'(last_q) + k;
            if (c >= NREQ) c = c - NREQ;
            if (elig[IW'(c)]) begin
                win     = IW'(c);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        lock_d     = lock_q;
        biu_rw_d   = biu_rw_q;
        biu_addr_d = biu_addr_q;
        biu_di_d   = biu_di_q;
        biu_ws_d   = biu_ws_q;
        req_do_d   = req_do_q;
        req_err_d  = req_err_q;
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        to_d       = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (lock_q && !lock_hold) begin
                    lock_d = 1'b0;
                    gnt_d  = '0;
                end
                if (bus.biu_rdy && win_vld) begin
                    last_d     = win;
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    biu_rw_d   = bus.req_rw[win];
                    biu_addr_d = bus.req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    biu_di_d   = bus.req_di[win*DATA_WIDTH +: DATA_WIDTH];
                    biu_ws_d   = bus.req_word_size[win*4 +: 4];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.biu_rdy) begin
                    req_do_d  = bus.biu_do;
                    req_err_d = bus.biu_err;
                    state_d   = DONE;
                end
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    req_do_d  = '0;
                    req_err_d = 1'b1;
                    to_d      = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (bus.req_lock[last_q]) lock_d = 1'b1;
                if (!(bus.req_lock[last_q] || lock_q)) gnt_d = '0;
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
                state_d = to_q ? DRAIN : IDLE;
                to_d    = 1'b0;
`else
                state_d = IDLE;
`endif
            end
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
            DRAIN: begin
                // The late response is swallowed; requester already got its error.
                if (bus.biu_rdy) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge biu_clk or negedge biu_rst_n) begin
        if (!biu_rst_n) begin
            state_q    <= IDLE;
            last_q     <= IW'(NREQ - 1);
            gnt_q      <= '0;
            lock_q     <= 1'b0;
            biu_rw_q   <= 1'b0;
            biu_addr_q <= '0;
            biu_di_q   <= '0;
            biu_ws_q   <= '0;
            req_do_q   <= '0;
            req_err_q  <= 1'b0;
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            lock_q     <= lock_d;
            biu_rw_q   <= biu_rw_d;
            biu_addr_q <= biu_addr_d;
            biu_di_q   <= biu_di_d;
            biu_ws_q   <= biu_ws_d;
            req_do_q   <= req_do_d;
            req_err_q  <= req_err_d;
`ifdef ADBG_BIU_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            to_q       <= to_d;
`endif
        end
    end

    // gnt_q holds the owner through DONE, so it doubles as the ack select.
    assign bus.req_gnt       = gnt_q;
    assign bus.req_ack       = (state_q == DONE) ? gnt_q : '0;
    assign bus.req_do        = req_do_q;
    assign bus.req_err       = req_err_q;
    assign bus.biu_strb      = (state_q == ISSUE);
    assign bus.biu_rw        = biu_rw_q;
    assign bus.biu_addr      = biu_addr_q;
    assign bus.biu_di        = biu_di_q;
    assign bus.biu_word_size = biu_ws_q;
endmodule

// File: tb/tb_adbg_biu_arb.sv
// Directed bench for adbg_biu_arb with a small latency-programmable BIU model.
// Latency: n/a.
// Backpressure: the BIU model holds biu_rdy low for a set number of cycles.
module tb_adbg_biu_arb;
    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adbg_biu_arb_if #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    adbg_biu_arb #(
        .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .biu_clk   (clk),
        .biu_rst_n (rst_n),
        .bus       (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // BIU model: drops biu_rdy on a strobe, raises it biu_lat cycles later.
    int          biu_lat  = 1;
    logic        biu_hold = 1'b0;
    logic [31:0] rsp_do   = '0;
    logic        rsp_err  = 1'b0;
    int          strb_cnt = 0;
    int          busy     = 0;

    initial begin
        bus.biu_rdy = 1'b1;
        bus.biu_do  = '0;
        bus.biu_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy        = 0;
                bus.biu_rdy = 1'b1;
            end else if (bus.biu_strb) begin
                strb_cnt++;
                bus.biu_rdy = 1'b0;
                busy        = biu_lat;
            end else if (busy > 0 && !biu_hold) begin
                busy--;
                if (busy == 0) begin
                    bus.biu_rdy = 1'b1;
                    bus.biu_do  = rsp_do;
                    bus.biu_err = rsp_err;
                end
            end
        end
    end

    task automatic set_req(input int i, input logic rw, input logic [31:0] addr,
                           input logic [31:0] di, input logic [3:0] ws);
        bus.req_rw[i]                = rw;
        bus.req_addr[i*AW +: AW]     = addr;
        bus.req_di[i*DW +: DW]       = di;
        bus.req_word_size[i*4 +: 4]  = ws;
    endtask

    // Counts negedges from the call until req_ack is seen.
    task automatic wait_ack(input string tag, output logic [NREQ-1:0] ack,
                            output logic [31:0] rdo, output logic rerr, output int lat);
        ack = '0; rdo = '0; rerr = 1'b0; lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (|bus.req_ack) begin
                ack  = bus.req_ack;
                rdo  = bus.req_do;
                rerr = bus.req_err;
                lat  = i;
                break;
            end
        end
        chk(tag, 64'(lat != 0), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [NREQ-1:0] ack;
    logic [31:0]     rdo;
    logic            rerr;
    int              lat;
    int              sbase;
    logic [NREQ-1:0] seen;

    initial begin
        bus.req_strb = '0; bus.req_rw = '0; bus.req_lock = '0;
        bus.req_addr = '0; bus.req_di = '0; bus.req_word_size = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",  64'(bus.req_gnt), 64'h0);
        chk("rst_ack",  64'(bus.req_ack), 64'h0);
        chk("rst_strb", 64'(bus.biu_strb), 64'h0);
        chk("rst_addr", 64'(bus.biu_addr), 64'h0);
        chk("rst_rw",   64'(bus.biu_rw), 64'h0);
        chk("rst_di",   64'(bus.biu_di), 64'h0);
        chk("rst_ws",   64'(bus.biu_word_size), 64'h0);
        chk("rst_do",   64'(bus.req_do), 64'h0);
        chk("rst_err",  64'(bus.req_err), 64'h0);
        rst_n = 1'b1;

        // Single read, BIU ready 3 cycles after strobe
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'h100, 32'h0, 4'd4);
        set_req(1, 1'b0, 32'hAAA, 32'h0, 4'd1);
        rsp_do = 32'hDEADBEEF; rsp_err = 1'b0; biu_lat = 3; sbase = strb_cnt;
        bus.req_strb = 2'b01;
        wait_ack("rd_ack_seen", ack, rdo, rerr, lat);
        chk("rd_ack",  64'(ack), 64'h1);
        chk("rd_gnt",  64'(bus.req_gnt), 64'h1);
        chk("rd_do",   64'(rdo), 64'hDEADBEEF);
        chk("rd_err",  64'(rerr), 64'h0);
        chk("rd_lat",  64'(lat), 64'd6);
        chk("rd_addr", 64'(bus.biu_addr), 64'h100);
        chk("rd_rw",   64'(bus.biu_rw), 64'h1);
        chk("rd_nstrb", 64'(strb_cnt - sbase), 64'd1);
        @(posedge clk); #1;
        bus.req_strb[0] = 1'b0;
        set_req(0, 1'b0, 32'h999, 32'h0, 4'd1);
        @(negedge clk);
        chk("rd_ack_once",  64'(bus.req_ack), 64'h0);
        chk("rd_do_hold",   64'(bus.req_do), 64'hDEADBEEF);
        chk("rd_gnt_free",  64'(bus.req_gnt), 64'h0);
        chk("rd_addr_hold", 64'(bus.biu_addr), 64'h100);
        chk("rd_nstrb_end", 64'(strb_cnt - sbase), 64'd1);

        // Write of 2 bytes with a bus error
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h202, 32'h1234, 4'd2);
        rsp_do = 32'h55; rsp_err = 1'b1; biu_lat = 2;
        bus.req_strb = 2'b01;
        wait_ack("wr_ack_seen", ack, rdo, rerr, lat);
        chk("wr_ack",  64'(ack), 64'h1);
        chk("wr_err",  64'(rerr), 64'h1);
        chk("wr_lat",  64'(lat), 64'd5);
        chk("wr_rw",   64'(bus.biu_rw), 64'h0);
        chk("wr_ws",   64'(bus.biu_word_size), 64'd2);
        chk("wr_di",   64'(bus.biu_di), 64'h1234);
        chk("wr_addr", 64'(bus.biu_addr), 64'h202);
        @(posedge clk); #1;
        bus.req_strb = '0;
        rsp_err = 1'b0;

        // Requester 1 drops strobe right after grant; ack still comes
        @(posedge clk); #1;
        set_req(1, 1'b1, 32'h1F0, 32'h0, 4'd4);
        rsp_do = 32'h0BAD_F00D; biu_lat = 1;
        bus.req_strb = 2'b10;
        @(posedge clk); #1;
        bus.req_strb = '0;
        wait_ack("ab_ack_seen", ack, rdo, rerr, lat);
        chk("ab_ack",  64'(ack), 64'h2);
        chk("ab_addr", 64'(bus.biu_addr), 64'h1F0);
        chk("ab_do",   64'(rdo), 64'h0BADF00D);

        // Reset in WAIT
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'h700, 32'h0, 4'd4);
        biu_hold = 1'b1; biu_lat = 3;
        bus.req_strb = 2'b01;
        repeat (4) @(negedge clk);
        chk("mr_gnt_pre", 64'(bus.req_gnt), 64'h1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mr_gnt",  64'(bus.req_gnt), 64'h0);
        chk("mr_ack",  64'(bus.req_ack), 64'h0);
        chk("mr_strb", 64'(bus.biu_strb), 64'h0);
        chk("mr_addr", 64'(bus.biu_addr), 64'h0);
        chk("mr_rw",   64'(bus.biu_rw), 64'h0);
        chk("mr_do",   64'(bus.req_do), 64'h0);
        chk("mr_err",  64'(bus.req_err), 64'h0);
        bus.req_strb = '0;
        biu_hold = 1'b0;
        seen = '0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | bus.req_ack;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            seen = seen | bus.req_ack;
        end
        chk("mr_no_ack", 64'(seen), 64'h0);

        // Simultaneous requests alternate, requester 0 first after reset
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'h300, 32'h0, 4'd4);
        set_req(1, 1'b1, 32'h400, 32'h0, 4'd4);
        biu_lat = 1;
        bus.req_strb = 2'b11;
        for (int j = 0; j < 4; j++) begin
            int w;
            w = (j % 2 == 0) ? 0 : 1;
            wait_ack("rr_ack_seen", ack, rdo, rerr, lat);
            chk("rr_owner", 64'(ack), (j % 2 == 0) ? 64'h1 : 64'h2);
            chk("rr_addr",  64'(bus.biu_addr), (j % 2 == 0) ? 64'h300 : 64'h400);
            @(posedge clk); #1;
            if (j == 3) begin
                bus.req_strb = '0;
            end else begin
                bus.req_strb[w] = 1'b0;
                @(posedge clk); #1;
                bus.req_strb[w] = 1'b1;
            end
        end
        repeat (3) @(posedge clk);

        // Lock: requester 1 keeps the bus for three accesses
        #1;
        set_req(1, 1'b1, 32'h500, 32'h0, 4'd4);
        set_req(0, 1'b1, 32'h600, 32'h0, 4'd4);
        bus.req_lock = 2'b10;
        bus.req_strb = 2'b10;
        @(posedge clk); #1;
        bus.req_strb[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ack("lk_ack_seen", ack, rdo, rerr, lat);
            chk("lk_owner", 64'(ack), 64'h2);
            @(posedge clk); #1;
            bus.req_strb[1] = 1'b0;
            if (k == 2) bus.req_lock[1] = 1'b0;
            @(negedge clk);
            chk("lk_gnt_held", 64'(bus.req_gnt), 64'h2);
            if (k < 2) begin
                @(posedge clk); #1;
                bus.req_strb[1] = 1'b1;
            end
        end
        wait_ack("lk_rel_seen", ack, rdo, rerr, lat);
        chk("lk_rel_owner", 64'(ack), 64'h1);
        chk("lk_rel_addr",  64'(bus.biu_addr), 64'h600);
        @(posedge clk); #1;
        bus.req_strb = '0;

`ifdef ADBG_BIU_ARB_TIMEOUT_EN
        // WAIT timeout, then drain of the late response
        @(posedge clk); #1;
        biu_hold = 1'b1; biu_lat = 2; rsp_do = 32'hCAFE; rsp_err = 1'b0;
        bus.req_strb = 2'b01;
        wait_ack("to_ack_seen", ack, rdo, rerr, lat);
        chk("to_ack", 64'(ack), 64'h1);
        chk("to_err", 64'(rerr), 64'h1);
        chk("to_do",  64'(rdo), 64'h0);
        chk("to_lat", 64'(lat), 64'd19);
        @(posedge clk); #1;
        bus.req_strb = 2'b10;
        seen = '0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | bus.req_gnt;
        end
        chk("to_no_gnt", 64'(seen), 64'h0);
        chk("to_do_kept", 64'(bus.req_do), 64'h0);
        biu_hold = 1'b0;
        wait_ack("to_next_seen", ack, rdo, rerr, lat);
        chk("to_next_ack", 64'(ack), 64'h2);
        chk("to_next_do",  64'(rdo), 64'hCAFE);
        chk("to_next_err", 64'(rerr), 64'h0);
        @(posedge clk); #1;
        bus.req_strb = '0;
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/adbg_biu_arb.md
ADBG_BIU_ARB -- requirements
Module: adbg_biu_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, BIU address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, BIU data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, wait-limit in cycles, used only under REQ-026.
REQ-005 SHALL have ports, one clock and an asynchronous active-low reset:
- biu_clk  in  1  sole clock
- biu_rst_n  in  1  asynchronous active-low reset
- req_strb  in  NREQ  per-requester access request, level, held until req_ack
- req_rw  in  NREQ  1=read, 0=write
- req_lock  in  NREQ  hold grant after this access
- req_addr  in  NREQ*ADDR_WIDTH  packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_di  in  NREQ*DATA_WIDTH  packed write data
- req_word_size  in  NREQ*4  packed byte count (1, 2, 4)
- req_ack  out  NREQ  one-cycle completion pulse to the granted requester
- req_gnt  out  NREQ  one-hot current owner, all-zero when free
- req_do  out  DATA_WIDTH  read data, valid in req_ack cycle
- req_err  out  1  bus error, valid in req_ack cycle
- biu_strb  out  1  one-cycle start strobe to BIU
- biu_rw, biu_addr, biu_di, biu_word_size  out  1/ADDR_WIDTH/DATA_WIDTH/4  registered copy of the granted request
- biu_rdy, biu_do, biu_err  in  1/DATA_WIDTH/1  BIU ready, read data, error

Function
REQ-006 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE (plus DRAIN, REQ-027).
REQ-007 IDLE: when biu_rdy=1 and some req_strb=1, SHALL select a winner, latch its fields into biu_* registers, set req_gnt, go to ISSUE.
REQ-008 Selection SHALL be round-robin: search from (last_owner+1) mod NREQ upward; last_owner updated on each grant.
REQ-009 If a lock is held (REQ-014), only the lock owner's req_strb SHALL be accepted in IDLE.
REQ-010 IDLE with biu_rdy=0 SHALL accept nothing.
REQ-011 ISSUE: biu_strb=1 for exactly this cycle; next state WAIT.
REQ-012 WAIT: SHALL remain until biu_rdy=1, then capture biu_do/biu_err into req_do/req_err, go to DONE.
REQ-013 DONE: req_ack[owner]=1 for exactly one cycle; next state IDLE; req_gnt cleared unless lock held.
REQ-014 Lock SHALL be set when req_lock[owner]=1 in DONE; cleared when req_lock[owner]=0 in IDLE.
REQ-015 Requesters SHALL drop req_strb on the edge that samples req_ack; req_strb high in IDLE is a new request.
REQ-016 Access latency SHALL be: 1 cycle IDLE->ISSUE, 1 ISSUE, BIU time in WAIT, 1 DONE.
REQ-017 req_do/req_err SHALL hold their last captured values outside req_ack.
REQ-018 Non-granted requesters' field changes SHALL not affect biu_* outputs.
REQ-019 A requester dropping req_strb after grant SHALL not abort the access; ack still issued.
REQ-020 biu_strb SHALL never assert outside ISSUE.

Reset
REQ-021 On biu_rst_n=0, asynchronously: state IDLE, biu_strb=0, req_ack=0, req_gnt=0, lock clear.
REQ-022 On reset: biu_rw, biu_addr, biu_di, biu_word_size, req_do, req_err =0.
REQ-023 On reset: last_owner=NREQ-1, so requester 0 wins first contention.
REQ-024 Reset mid-access SHALL abandon the access without req_ack.

Configuration
REQ-025 Macro ADBG_BIU_ARB_TIMEOUT_EN SHALL select the wait timeout.
REQ-026 Defined: WAIT counts cycles; at TIMEOUT_CYCLES without biu_rdy, SHALL issue req_ack with req_err=1, req_do=0, go to DRAIN.
REQ-027 DRAIN: SHALL wait for biu_rdy=1, discard biu_do/biu_err, go to IDLE; no ack.
REQ-028 Undefined: no counter, no DRAIN; WAIT unbounded.

Verification
REQ-029 Reset, req_strb=01, rw=1, addr=0x100, BIU rdy returns 3 cycles after strobe with do=0xDEADBEEF -> one biu_strb, biu_addr=0x100, req_ack[0] with req_do=0xDEADBEEF, err=0.
REQ-030 Both strobe in same IDLE cycle, repeatedly -> grants alternate 0,1,0,1.
REQ-031 Requester 1 req_lock=1 for 3 accesses while requester 0 strobes -> three grants to 1, then 0 granted once lock drops.
REQ-032 Write, word_size=2, addr=0x202, di=0x1234, biu_err=1 -> biu_rw=0, biu_word_size=2, req_ack with req_err=1.
REQ-033 With ADBG_BIU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, biu_rdy low 40 cycles -> req_ack, req_err=1 at cycle 16 of WAIT; no new grant until biu_rdy=1.
REQ-034 biu_rst_n low during WAIT -> all outputs zero immediately, no req_ack; next request served by requester 0.
